divider: RTL and testbench
==========================

# divider

Sequential 32-bit signed integer divider for the datapath's HI/LO unit; it is the inverse of the Booth multiplier. It accepts a dividend/divisor pair on a `start` pulse and runs a restoring shift-subtract loop, one quotient bit per clock. It returns a quotient (written to LO) and a remainder (written to HI), rounded toward zero, with a `finished` flag. The control unit holds the operands stable and waits on `finished` before latching LO/HI.

## Interface
- No parameters; width fixed at 32 bits.
- `clk`  input  1  system clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `start`  input  1  level-sampled; high at a rising edge loads operands and begins (or restarts) a division.
- `dividend`  input  32  signed two's-complement dividend; sampled only on a `start` edge.
- `divisor`  input  32  signed two's-complement divisor; sampled only on a `start` edge.
- `quotient`  output  32  signed quotient, truncated toward zero (LO).
- `remainder`  output  32  signed remainder; sign follows dividend (HI).
- `finished`  output  1  high while a valid result is held.
- `busy`  output  1  high while a division is in progress.
- `div_by_zero`  output  1  high with `finished` when the captured divisor was 0.

## Operation
- States: IDLE, CALC, FIX, DONE. Reset → IDLE.
- Reset values: `quotient`=0, `remainder`=0, `finished`=0, `busy`=0, `div_by_zero`=0, internal count=0.
- `start`=1 at an edge, in any state: capture |dividend| and |divisor| as 32-bit unsigned magnitudes. Capture the quotient sign (dividend[31]^divisor[31]) and remainder sign (dividend[31]). Zero the partial remainder (33 bits), set count=0, clear `quotient`/`remainder`/`finished`/`div_by_zero`, and go to CALC. `start` takes priority over every other transition, so asserting it mid-operation aborts and restarts. Holding it high keeps reloading.
- CALC: each cycle, shift {partial remainder, dividend magnitude} left by 1 and trial-subtract the divisor magnitude from the partial remainder.
  - Result non-negative: keep it and shift in quotient bit 1.
  - Result negative: restore the partial remainder and shift in 0.
  - Increment count; after the 32nd iteration (count reaches 32), go to FIX.
- FIX (one cycle):
  - Quotient is negated if the quotient sign is set.
  - Remainder is negated if the remainder sign is set.
  - Write `quotient` and `remainder`, set `finished`=1, and go to DONE.
- Divisor = 0: the loop still runs with full latency. In FIX, force `quotient`=0, `remainder`=dividend (original signed value), and `div_by_zero`=1.
- Overflow case 0x80000000 / 0xFFFFFFFF: magnitude quotient 0x80000000; both signs negative, so no negation; `quotient`=0x80000000, `remainder`=0. No overflow flag.
- DONE: hold all outputs until the next `start` or `reset`. IDLE and DONE ignore operand changes.
- `busy`=1 in CALC and FIX, 0 otherwise.

## Timing
- Edge N samples `start`=1 (load). Edges N+1..N+32 perform the iterations. Edge N+33 performs FIX. `finished`, `quotient`, `remainder` and `div_by_zero` become valid after edge N+33: fixed latency of 33 cycles, independent of operand values.
- `busy` is high from after edge N to after edge N+33.
- `finished` falls after the next `start` edge; it is never high while `busy` is high.
- `reset` asserted mid-CALC: outputs zero immediately, without waiting for a clock edge. After `reset` deasserts, the block stays in IDLE until `start`.
- Operands need only be valid at the `start` edge.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- dividend=100, divisor=7, one-cycle `start` → after 33 cycles `quotient`=14, `remainder`=2, `finished`=1, `div_by_zero`=0; outputs hold for 10 further cycles.
- Signed cases: −100/7 → `quotient`=0xFFFFFFF2, `remainder`=0xFFFFFFFE; 100/−7 → `quotient`=0xFFFFFFF2, `remainder`=2; −100/−7 → `quotient`=14, `remainder`=0xFFFFFFFE.
- 0x80000000 / 0xFFFFFFFF → `quotient`=0x80000000, `remainder`=0. 0xFFFFFFFF / 0x80000000 → `quotient`=0, `remainder`=0xFFFFFFFF.
- divisor=0, dividend=1234 → after 33 cycles `quotient`=0, `remainder`=1234, `div_by_zero`=1, `finished`=1.
- Start 100/7, re-assert `start` with 50/5 at cycle 10 → `finished` stays 0 until 33 cycles after the second start; then `quotient`=10, `remainder`=0.
- Assert `reset` asynchronously at cycle 15 of a division → all outputs 0 immediately. No `finished` appears afterwards until a new `start`, which then completes normally.

Source files
------------

// File: rtl/divider.sv
// divider
// Sequential 32-bit signed integer divider feeding the HI/LO unit.
// A restoring shift-subtract loop produces one quotient bit per clock;
// results are truncated toward zero with the remainder taking the sign
// of the dividend.
// Latency is a fixed 33 cycles after the start edge: 32 iterations plus
// one sign-fixup cycle.
//
// Ports
//   clk          in   system clock, rising-edge active
//   reset        in   asynchronous active-high reset
//   start        in   load operands and (re)start a division
//   dividend     in   32-bit signed dividend, sampled on a start edge
//   divisor      in   32-bit signed divisor, sampled on a start edge
//   quotient     out  32-bit signed quotient (LO)
//   remainder    out  32-bit signed remainder (HI)
//   finished     out  a valid result is being held
//   busy         out  a division is in progress
//   div_by_zero  out  the captured divisor was zero (valid with finished)

module divider (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        finished,
   output logic        busy,
   output logic        div_by_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state_q;
   logic [31:0] dvd_q;    // dividend magnitude; quotient bits shift in at bit 0
   logic [31:0] dsr_q;    // divisor magnitude
   logic [31:0] orig_q;   // original signed dividend, returned on divide-by-zero
   logic [32:0] prem_q;   // partial remainder
   logic [5:0]  cnt_q;
   logic        qneg_q;
   logic        rneg_q;
   logic        zero_q;

   logic [31:0] quot_q;
   logic [31:0] rem_q;
   logic        fin_q;
   logic        busy_q;
   logic        dbz_q;

   logic [31:0] dvd_abs;
   logic [31:0] dsr_abs;
   logic [33:0] trial;
   logic        trial_neg;
   logic [32:0] prem_d;
   logic [31:0] dvd_d;

   // Operand magnitudes; 0x80000000 maps onto itself, which is the correct
   // unsigned magnitude.
   always_comb begin
      dvd_abs = dividend[31] ? (~dividend + 32'd1) : dividend;
      dsr_abs = divisor[31]  ? (~divisor  + 32'd1) : divisor;
   end

   // One restoring step. The shifted partial remainder is below
   // 2*divisor, so a 34-bit difference carries a reliable sign in bit 33.
   always_comb begin
      trial     = {prem_q, dvd_q[31]} - {2'b00, dsr_q};
      trial_neg = trial[33];
      prem_d    = trial_neg ? {prem_q[31:0], dvd_q[31]} : trial[32:0];
      dvd_d     = {dvd_q[30:0], ~trial_neg};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         dsr_q   <= '0;
         orig_q  <= '0;
         prem_q  <= '0;
         cnt_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         zero_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         fin_q   <= 1'b0;
         busy_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else if (start) begin
         // start overrides every state, so a mid-operation pulse restarts
         state_q <= CALC;
         dvd_q   <= dvd_abs;
         dsr_q   <= dsr_abs;
         orig_q  <= dividend;
         prem_q  <= '0;
         cnt_q   <= '0;
         qneg_q  <= dividend[31] ^ divisor[31];
         rneg_q  <= dividend[31];
         zero_q  <= (divisor == '0);
         quot_q  <= '0;
         rem_q   <= '0;
         fin_q   <= 1'b0;
         busy_q  <= 1'b1;
         dbz_q   <= 1'b0;
      end else begin
         case (state_q)
            CALC: begin
               prem_q <= prem_d;
               dvd_q  <= dvd_d;
               cnt_q  <= cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               if (zero_q) begin
                  quot_q <= '0;
                  rem_q  <= orig_q;
                  dbz_q  <= 1'b1;
               end else begin
                  quot_q <= qneg_q ? (~dvd_q + 32'd1) : dvd_q;
                  rem_q  <= rneg_q ? (~prem_q[31:0] + 32'd1) : prem_q[31:0];
                  dbz_q  <= 1'b0;
               end
               fin_q   <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= DONE;
            end
            IDLE, DONE: begin
               // hold everything until the next start
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign finished    = fin_q;
   assign busy        = busy_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// tb_divider
// Self-checking bench for divider. A cycle-level reference model derives
// the expected outputs from plain signed 64-bit arithmetic and a
// 33-cycle latency countdown; a compare process checks every cycle on the
// falling edge. Directed vectors additionally pin literal results.

module tb_divider;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        finished;
   logic        busy;
   logic        div_by_zero;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic        chk_en = 1'b0;

   divider dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .finished    (finished),
      .busy        (busy),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r,
                                   output logic z);
      longint sa;
      longint sb;
      longint qq;
      longint rr;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) begin
         q = '0;
         r = a;
         z = 1'b1;
      end else begin
         qq = sa / sb;
         rr = sa % sb;
         q  = qq[31:0];
         r  = rr[31:0];
         z  = 1'b0;
      end
   endfunction

   logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
   logic        m_fin = 1'b0, m_busy = 1'b0, m_z = 1'b0, p_z = 1'b0;
   int          m_cnt = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q = '0; m_r = '0; m_fin = 1'b0; m_busy = 1'b0; m_z = 1'b0; m_cnt = 0;
      end else if (start) begin
         ref_div(dividend, divisor, p_q, p_r, p_z);
         m_q = '0; m_r = '0; m_fin = 1'b0; m_z = 1'b0; m_busy = 1'b1; m_cnt = 33;
      end else if (m_cnt > 0) begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 0) begin
            m_q = p_q; m_r = p_r; m_z = p_z; m_fin = 1'b1; m_busy = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_cmp++;
         if ({quotient, remainder, finished, busy, div_by_zero} !==
             {m_q, m_r, m_fin, m_busy, m_z}) begin
            n_err++;
            $display("FAIL cycle_model t=%0t: got q=%h r=%h fin=%b busy=%b dbz=%b, want q=%h r=%h fin=%b busy=%b dbz=%b",
                     $time, quotient, remainder, finished, busy, div_by_zero,
                     m_q, m_r, m_fin, m_busy, m_z);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez);
      int lat;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      lat = 0;
      while (!finished && lat < 40) begin
         tick();
         lat++;
      end
      chk({name, "_latency"}, 32'(lat), 32'd33);
      chk({name, "_quotient"}, quotient, eq);
      chk({name, "_remainder"}, remainder, er);
      chk({name, "_finished"}, {31'd0, finished}, 32'd1);
      chk({name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int seen_fin;
      repeat (3) tick();
      chk_en = 1'b1;
      chk("reset_quotient", quotient, 32'h0);
      chk("reset_flags", {29'd0, finished, busy, div_by_zero}, 32'h0);
      reset = 1'b0;
      tick();

      do_div("pos", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      repeat (10) tick();
      chk("hold_quotient", quotient, 32'd14);
      chk("hold_remainder", remainder, 32'd2);
      chk("hold_finished", {31'd0, finished}, 32'd1);

      do_div("negdvd", 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
      do_div("negdsr", 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0);
      do_div("negboth", 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0);
      do_div("ovf", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0);
      do_div("minone", 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'hFFFFFFFF, 1'b0);
      do_div("divzero", 32'd1234, 32'd0, 32'h0, 32'd1234, 1'b1);

      // restart mid-division
      dividend = 32'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      do_div("restart", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);

      // asynchronous reset mid-division
      dividend = 32'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (14) tick();
      chk("pre_reset_busy", {31'd0, busy}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_quotient", quotient, 32'h0);
      chk("async_remainder", remainder, 32'h0);
      chk("async_flags", {29'd0, finished, busy, div_by_zero}, 32'h0);
      tick();
      tick();
      reset = 1'b0;
      seen_fin = 0;
      repeat (40) begin
         tick();
         if (finished) seen_fin++;
      end
      chk("no_finish_after_reset", 32'(seen_fin), 32'd0);
      do_div("post_reset", 32'd1000, 32'hFFFFFFFD, 32'hFFFFFEB3, 32'd1, 1'b0);

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
